// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-granular round-robin arbiter onto the MAC TX AXIS channel
//
// Purpose: shares one TX AXIS channel between num_req_p frame sources. A grant is held
// for a whole frame (until tlast). Frames that run past max_frame_beats_p are cut short
// with tlast+tuser and their remainder is discarded. Frame and truncation counters are kept.
//
// Ports:
//   bp_clk_i, bp_reset_i           clock, synchronous active-high reset
//   req_t{data,keep,valid,last,user}_i / req_tready_o
//                                   per-requester AXIS slave ports (packed, requester 0 in LSBs)
//   tx_axis_t{data,keep,valid,last,user}_o / tx_axis_tready_i
//                                   AXIS master port into the MAC TX FIFO
//   grant_id_o                     current or most recent granted requester
//   busy_o                         a frame is being forwarded or drained
//   frames_sent_o, frames_trunc_o  wrapping frame statistics
module eth_tx_frame_arbiter #(
  parameter int num_req_p         = 2,
  parameter int axis_data_width_p = 64,
  parameter int max_frame_beats_p = 190,
  parameter int stat_width_p      = 16,
  localparam int keep_w_lp        = axis_data_width_p / 8,
  localparam int grant_w_lp       = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                   bp_clk_i,
  input  logic                                   bp_reset_i,
  input  logic [num_req_p*axis_data_width_p-1:0] req_tdata_i,
  input  logic [num_req_p*keep_w_lp-1:0]         req_tkeep_i,
  input  logic [num_req_p-1:0]                   req_tvalid_i,
  output logic [num_req_p-1:0]                   req_tready_o,
  input  logic [num_req_p-1:0]                   req_tlast_i,
  input  logic [num_req_p-1:0]                   req_tuser_i,
  output logic [axis_data_width_p-1:0]           tx_axis_tdata_o,
  output logic [keep_w_lp-1:0]                   tx_axis_tkeep_o,
  output logic                                   tx_axis_tvalid_o,
  input  logic                                   tx_axis_tready_i,
  output logic                                   tx_axis_tlast_o,
  output logic                                   tx_axis_tuser_o,
  output logic [grant_w_lp-1:0]                  grant_id_o,
  output logic                                   busy_o,
  output logic [stat_width_p-1:0]                frames_sent_o,
  output logic [stat_width_p-1:0]                frames_trunc_o
);

  localparam int beat_w_lp = $clog2(max_frame_beats_p + 1);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [grant_w_lp-1:0]   grant_q, grant_d;
  logic [beat_w_lp-1:0]    beat_cnt_q, beat_cnt_d;
  logic [stat_width_p-1:0] frames_sent_q, frames_sent_d;
  logic [stat_width_p-1:0] frames_trunc_q, frames_trunc_d;

  logic                    g_valid, g_last, g_user;
  logic                    at_max, force_end, hs;
  logic                    found;
  logic [grant_w_lp-1:0]   pick;
  int                      idx;

  assign g_valid = req_tvalid_i[grant_q];
  assign g_last  = req_tlast_i[grant_q];
  assign g_user  = req_tuser_i[grant_q];
  assign hs      = g_valid & tx_axis_tready_i;

  // Last permitted beat: if the source has not ended the frame here, end it for it.
  assign at_max    = (beat_cnt_q == beat_w_lp'(max_frame_beats_p - 1));
  assign force_end = at_max & ~g_last;

  // Round-robin pick: first valid requester searching upward from the one after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    idx   = 0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = (int'(grant_q) + i) % num_req_p;
      if (!found && req_tvalid_i[idx]) begin
        found = 1'b1;
        pick  = grant_w_lp'(idx);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    beat_cnt_d       = beat_cnt_q;
    frames_sent_d    = frames_sent_q;
    frames_trunc_d   = frames_trunc_q;
    req_tready_o     = '0;
    tx_axis_tdata_o  = '0;
    tx_axis_tkeep_o  = '0;
    tx_axis_tvalid_o = 1'b0;
    tx_axis_tlast_o  = 1'b0;
    tx_axis_tuser_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = PASS;
        end
      end

      PASS: begin
        tx_axis_tdata_o       = req_tdata_i[int'(grant_q)*axis_data_width_p +: axis_data_width_p];
        tx_axis_tkeep_o       = req_tkeep_i[int'(grant_q)*keep_w_lp +: keep_w_lp];
        tx_axis_tvalid_o      = g_valid;
        tx_axis_tlast_o       = g_last | force_end;
        tx_axis_tuser_o       = g_user | force_end;
        req_tready_o[grant_q] = tx_axis_tready_i;
        if (hs) begin
          beat_cnt_d = beat_cnt_q + beat_w_lp'(1);
          if (g_last) begin
            frames_sent_d = frames_sent_q + stat_width_p'(1);
            state_d       = IDLE;
          end else if (at_max) begin
            frames_sent_d  = frames_sent_q + stat_width_p'(1);
            frames_trunc_d = frames_trunc_q + stat_width_p'(1);
            state_d        = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The MAC already saw tlast; swallow the rest of the source frame.
        req_tready_o[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bp_clk_i) begin
    if (bp_reset_i) begin
      state_q        <= IDLE;
      grant_q        <= grant_w_lp'(num_req_p - 1);
      beat_cnt_q     <= '0;
      frames_sent_q  <= '0;
      frames_trunc_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      beat_cnt_q     <= beat_cnt_d;
      frames_sent_q  <= frames_sent_d;
      frames_trunc_q <= frames_trunc_d;
    end
  end

  assign grant_id_o     = grant_q;
  assign busy_o         = (state_q != IDLE);
  assign frames_sent_o  = frames_sent_q;
  assign frames_trunc_o = frames_trunc_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - directed self-checking bench for eth_tx_frame_arbiter
//
// Purpose: drives two AXIS frame sources and a MAC-side tready pattern, captures every
// tx_axis handshake and compares the captured beat stream and statistics against
// expected frame sequences.
module tb_eth_tx_frame_arbiter;

  localparam int NR  = 2;
  localparam int W   = 64;
  localparam int MAX = 190;

  logic            clk = 1'b0;
  logic            bp_reset_i;
  logic [NR*W-1:0] req_tdata;
  logic [NR*8-1:0] req_tkeep;
  logic [NR-1:0]   req_tvalid, req_tready, req_tlast, req_tuser;
  logic [W-1:0]    tx_tdata;
  logic [7:0]      tx_tkeep;
  logic            tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic [0:0]      grant_id;
  logic            busy;
  logic [15:0]     frames_sent, frames_trunc;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(
    .num_req_p(NR), .axis_data_width_p(W), .max_frame_beats_p(MAX), .stat_width_p(16)
  ) dut (
    .bp_clk_i(clk), .bp_reset_i(bp_reset_i),
    .req_tdata_i(req_tdata), .req_tkeep_i(req_tkeep), .req_tvalid_i(req_tvalid),
    .req_tready_o(req_tready), .req_tlast_i(req_tlast), .req_tuser_i(req_tuser),
    .tx_axis_tdata_o(tx_tdata), .tx_axis_tkeep_o(tx_tkeep), .tx_axis_tvalid_o(tx_tvalid),
    .tx_axis_tready_i(tx_tready), .tx_axis_tlast_o(tx_tlast), .tx_axis_tuser_o(tx_tuser),
    .grant_id_o(grant_id), .busy_o(busy),
    .frames_sent_o(frames_sent), .frames_trunc_o(frames_trunc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Source model state
  int s_nfr[NR], s_fr[NR], s_bt[NR], s_delay[NR], s_drop_at[NR], s_hold[NR];
  int s_len[NR][8];
  bit s_bad[NR][8];
  bit src_hs[NR];
  bit toggle_ready;
  int first_hs;

  logic [73:0] obs_q[$];
  logic [73:0] exp_q[$];

  function automatic logic [63:0] bw(input int r, input int f, input int b);
    return {16'hA5C3, 16'(r), 16'(f), 16'(b)};
  endfunction

  task automatic clear_all();
    for (int r = 0; r < NR; r++) begin
      s_nfr[r] = 0; s_fr[r] = 0; s_bt[r] = 0; s_delay[r] = 0; s_drop_at[r] = -1; s_hold[r] = 0;
    end
    toggle_ready = 1'b0;
    first_hs = -1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic add_src(input int r, input int len, input bit bad);
    s_len[r][s_nfr[r]] = len;
    s_bad[r][s_nfr[r]] = bad;
    s_nfr[r]++;
  endtask

  // Expected tx beats of frame f of requester r, including truncation at MAX beats.
  task automatic add_exp(input int r, input int f, input int len, input bit bad);
    int n;
    n = (len < MAX) ? len : MAX;
    for (int b = 0; b < n; b++) begin
      exp_q.push_back({bw(r, f, b), (b == len - 1) ? 8'h0F : 8'hFF,
                       (b == len - 1) || (b == MAX - 1),
                       ((b == len - 1) && bad) || ((b == MAX - 1) && (len > MAX))});
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (s_fr[r] < s_nfr[r] && s_delay[r] == 0 && s_hold[r] == 0) begin
        req_tvalid[r]        = 1'b1;
        req_tdata[r*W +: W]  = bw(r, s_fr[r], s_bt[r]);
        req_tlast[r]         = (s_bt[r] == s_len[r][s_fr[r]] - 1);
        req_tuser[r]         = req_tlast[r] & s_bad[r][s_fr[r]];
        req_tkeep[r*8 +: 8]  = req_tlast[r] ? 8'h0F : 8'hFF;
      end else begin
        req_tvalid[r]        = 1'b0;
        req_tdata[r*W +: W]  = '0;
        req_tlast[r]         = 1'b0;
        req_tuser[r]         = 1'b0;
        req_tkeep[r*8 +: 8]  = '0;
      end
    end
    tx_tready = toggle_ready ? ~tx_tready : 1'b1;
  endtask

  task automatic advance();
    for (int r = 0; r < NR; r++) begin
      if (s_delay[r] > 0) s_delay[r]--;
      if (s_hold[r] > 0) s_hold[r]--;
      if (src_hs[r]) begin
        s_bt[r]++;
        if (s_bt[r] == s_len[r][s_fr[r]]) begin
          s_fr[r]++;
          s_bt[r] = 0;
        end else if (s_fr[r] == 0 && s_bt[r] == s_drop_at[r]) begin
          s_hold[r] = 3;
        end
      end
    end
  endtask

  function automatic bit sources_done();
    for (int r = 0; r < NR; r++) if (s_fr[r] < s_nfr[r]) return 1'b0;
    return 1'b1;
  endfunction

  // Run from a posedge+#1 point; stop on completion (stop_beats==0) or after stop_beats tx beats.
  task automatic run(input string tag, input int max_cyc, input int stop_beats);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      if (tx_tvalid && tx_tready) begin
        obs_q.push_back({tx_tdata, tx_tkeep, tx_tlast, tx_tuser});
        if (first_hs < 0) first_hs = cyc;
      end
      for (int r = 0; r < NR; r++) src_hs[r] = req_tvalid[r] & req_tready[r];
      @(posedge clk);
      #1;
      cyc++;
      advance();
      drive();
      if (stop_beats > 0) done = (obs_q.size() >= stop_beats);
      else done = sources_done() && !busy;
    end
    if (!done) check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tvalid"}, tx_tvalid, 1'b0);
    check({tag, "_tready"}, req_tready, 2'b00);
    check({tag, "_tlast"},  tx_tlast, 1'b0);
    check({tag, "_tuser"},  tx_tuser, 1'b0);
    check({tag, "_busy"},   busy, 1'b0);
    check({tag, "_grant"},  grant_id, 1'b1);
    check({tag, "_sent"},   frames_sent, 16'd0);
    check({tag, "_trunc"},  frames_trunc, 16'd0);
  endtask

  task automatic do_reset(input string tag);
    bp_reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(tag);
    bp_reset_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bp_reset_i = 1'b1;
    tx_tready  = 1'b1;
    clear_all();
    drive();
    do_reset("rst0");

    // 1: single 3-beat frame, one arbitration cycle before the first beat
    clear_all();
    add_src(0, 3, 1'b0);
    add_exp(0, 0, 3, 1'b0);
    drive();
    run("t1", 100, 0);
    compare_stream("t1");
    check("t1_first_hs_cycle", first_hs, 1);
    check("t1_sent", frames_sent, 16'd1);
    check("t1_grant", grant_id, 1'b0);

    // 2: both sources, two frames each, alternate whole frames starting with req 0
    do_reset("rst2");
    clear_all();
    add_src(0, 2, 1'b0); add_src(0, 1, 1'b1);
    add_src(1, 3, 1'b1); add_src(1, 2, 1'b0);
    add_exp(0, 0, 2, 1'b0);
    add_exp(1, 0, 3, 1'b1);
    add_exp(0, 1, 1, 1'b1);
    add_exp(1, 1, 2, 1'b0);
    drive();
    run("t2", 200, 0);
    compare_stream("t2");
    check("t2_sent", frames_sent, 16'd4);
    check("t2_grant", grant_id, 1'b1);

    // 3: toggling tready, req 1 stalls mid-frame while req 0 waits for the grant
    clear_all();
    toggle_ready = 1'b1;
    add_src(1, 5, 1'b0);
    s_drop_at[1] = 2;
    add_src(0, 2, 1'b0);
    s_delay[0] = 2;
    add_exp(1, 0, 5, 1'b0);
    add_exp(0, 0, 2, 1'b0);
    drive();
    run("t3", 200, 0);
    compare_stream("t3");
    check("t3_sent", frames_sent, 16'd6);
    check("t3_grant", grant_id, 1'b0);

    // 4: 200-beat runaway frame truncated at beat 190, remaining 10 beats drained
    clear_all();
    add_src(0, 200, 1'b0);
    add_exp(0, 0, 200, 1'b0);
    drive();
    run("t4", 1000, 0);
    compare_stream("t4");
    check("t4_src_consumed", s_fr[0], 1);
    check("t4_sent", frames_sent, 16'd7);
    check("t4_trunc", frames_trunc, 16'd1);

    // 5: tlast exactly on beat 190 ends normally
    clear_all();
    add_src(0, MAX, 1'b0);
    add_exp(0, 0, MAX, 1'b0);
    drive();
    run("t5", 1000, 0);
    compare_stream("t5");
    check("t5_sent", frames_sent, 16'd8);
    check("t5_trunc", frames_trunc, 16'd1);

    // 6: reset mid-frame, then req 0 must win first again
    clear_all();
    add_src(0, 10, 1'b0);
    drive();
    run("t6a", 100, 5);
    check("t6_beats_before_rst", obs_q.size(), 5);
    check("t6_beat4", obs_q[4], {bw(0, 0, 4), 8'hFF, 1'b0, 1'b0});
    check("t6_grant_before_rst", grant_id, 1'b0);
    bp_reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("t6_rst");
    bp_reset_i = 1'b0;
    clear_all();
    add_src(0, 2, 1'b0);
    add_src(1, 2, 1'b0);
    add_exp(0, 0, 2, 1'b0);
    add_exp(1, 0, 2, 1'b0);
    drive();
    run("t6b", 200, 0);
    compare_stream("t6b");
    check("t6_sent", frames_sent, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
